// File: rtl/vga_pmod_formatter.sv
// VGA pin formatter for the Tiny Tapeout pads: ordered-dither depth reduction, single/dual
// PMOD pin mapping and frame-aligned mode switching, as a two-stage registered pipeline.
module vga_pmod_formatter #(
  parameter int unsigned IN_BITS         = 6,
  parameter bit          TEMPORAL        = 1'b1,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter logic [1:0]  MODE_RESET      = 2'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_BITS-1:0] r_in,
  input  logic [IN_BITS-1:0] g_in,
  input  logic [IN_BITS-1:0] b_in,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               de_in,
  input  logic [1:0]         mode_req,
  output logic [7:0]         uo_out,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe,
  output logic [1:0]         mode_active
);

  localparam int unsigned PIN_W     = 24;
  localparam int unsigned CH_W      = 4;
  localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW;

  // Pin map for one output mode; packs {uo, uio, oe}.
  function automatic logic [PIN_W-1:0] pin_map(input logic [1:0] mode,
                                               input logic [CH_W-1:0] r,
                                               input logic [CH_W-1:0] g,
                                               input logic [CH_W-1:0] b,
                                               input logic hs,
                                               input logic vs);
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
    uo  = '0;
    uio = '0;
    oe  = '0;
    case (mode)
      2'd0:    uo = {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
      2'd1: begin
        uo  = {b, r};
        uio = {2'b00, vs, hs, g};
        oe  = 8'hFF;
      end
      default: uo = {hs, 3'b000, vs, 3'b000};
    endcase
    return {uo, uio, oe};
  endfunction

  // Reduce one channel to o bits with threshold index t (o is 2 or 4).
  function automatic logic [CH_W-1:0] reduce(input logic [IN_BITS-1:0] c,
                                             input logic [1:0] t,
                                             input int unsigned o);
    logic [15:0] c16;
    logic [15:0] thr;
    logic [15:0] q;
    logic [15:0] maxv;
    c16  = 16'(c);
    maxv = (16'd1 << o) - 16'd1;
    if (IN_BITS <= o) begin
      q = c16 << (o - IN_BITS);
    end else begin
      thr = (16'(t) << (IN_BITS - o)) >> 2;
      q   = (c16 + thr) >> (IN_BITS - o);
      if (q > maxv) q = maxv;
    end
    return CH_W'(q);
  endfunction

  localparam logic [PIN_W-1:0] RST_PINS =
    pin_map(MODE_RESET, 4'd0, 4'd0, 4'd0, SYNC_IDLE, SYNC_IDLE);

  logic [1:0]       mode_s1_q, mode_sync_q, mode_q, mode_d;
  logic             vs_prev_q, de_prev_q;
  logic             px_q, px_d, ln_q, ln_d, fp_q, fp_d;
  logic [CH_W-1:0]  r1_q, g1_q, b1_q, r1_d, g1_d, b1_d;
  logic             hs1_q, vs1_q;
  logic [PIN_W-1:0] pins_q, pins_d;
  logic             vs_act, vs_edge;

  assign vs_act  = vs_in ^ SYNC_ACTIVE_LOW;
  assign vs_edge = vs_act & ~vs_prev_q;

  // Dither coordinates, frame-aligned mode adoption and stage-1 colour reduction.
  always_comb begin
    logic             x;
    logic             y;
    logic [1:0]       t;
    logic [IN_BITS-1:0] rc;
    logic [IN_BITS-1:0] gc;
    logic [IN_BITS-1:0] bc;
    int unsigned      o_bits;

    px_d   = de_in ? ~px_q : 1'b0;
    ln_d   = ln_q;
    if (vs_edge)                 ln_d = 1'b0;
    else if (de_prev_q && !de_in) ln_d = ~ln_q;
    fp_d   = fp_q ^ vs_edge;
    // Stage 1 reduces with the mode stage 2 will map with on the next cycle.
    mode_d = vs_edge ? mode_sync_q : mode_q;

    x = px_q ^ (fp_q & TEMPORAL);
    y = ln_q ^ (fp_q & TEMPORAL);
    case ({y, x})
      2'b00:   t = 2'd0;
      2'b01:   t = 2'd2;
      2'b10:   t = 2'd3;
      default: t = 2'd1;
    endcase

    rc     = de_in ? r_in : '0;
    gc     = de_in ? g_in : '0;
    bc     = de_in ? b_in : '0;
    o_bits = (mode_d == 2'd1) ? 32'd4 : 32'd2;
    r1_d   = reduce(rc, t, o_bits);
    g1_d   = reduce(gc, t, o_bits);
    b1_d   = reduce(bc, t, o_bits);

    pins_d = pin_map(mode_q, r1_q, g1_q, b1_q, hs1_q, vs1_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q   <= MODE_RESET;
      mode_sync_q <= MODE_RESET;
      mode_q      <= MODE_RESET;
      vs_prev_q   <= 1'b0;
      de_prev_q   <= 1'b0;
      px_q        <= 1'b0;
      ln_q        <= 1'b0;
      fp_q        <= 1'b0;
      r1_q        <= '0;
      g1_q        <= '0;
      b1_q        <= '0;
      hs1_q       <= SYNC_IDLE;
      vs1_q       <= SYNC_IDLE;
      pins_q      <= RST_PINS;
    end else begin
      mode_s1_q   <= mode_req;
      mode_sync_q <= mode_s1_q;
      mode_q      <= mode_d;
      vs_prev_q   <= vs_act;
      de_prev_q   <= de_in;
      px_q        <= px_d;
      ln_q        <= ln_d;
      fp_q        <= fp_d;
      r1_q        <= r1_d;
      g1_q        <= g1_d;
      b1_q        <= b1_d;
      hs1_q       <= hs_in;
      vs1_q       <= vs_in;
      pins_q      <= pins_d;
    end
  end

  assign uo_out      = pins_q[23:16];
  assign uio_out     = pins_q[15:8];
  assign uio_oe      = pins_q[7:0];
  assign mode_active = mode_q;

endmodule

// File: tb/tb_vga_pmod_formatter.sv
// Scoreboard bench for vga_pmod_formatter (IN_BITS=6, temporal dither, active-low syncs, mode 0 at reset).
module tb_vga_pmod_formatter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0;
  logic [1:0] mode_req = 2'd0;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [1:0] mode_active;

  vga_pmod_formatter dut (
    .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .mode_req(mode_req),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [7:0]  uo;
    logic [7:0]  uio;
    logic [7:0]  oe;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference state derived from the stimulus stream.
  logic       m_px = 0, m_ln = 0, m_fp = 0, m_de_prev = 0, m_vs_prev = 0;
  logic [1:0] m_mode = 2'd0, r_m1 = 2'd0, r_m2 = 2'd0, req = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] bayer(input logic x, input logic y);
    if (!x && !y) return 2'd0;
    if (x && !y)  return 2'd2;
    if (!x && y)  return 2'd3;
    return 2'd1;
  endfunction

  function automatic logic [3:0] dith(input logic [5:0] c, input logic de,
                                      input logic [1:0] mode, input logic [1:0] t);
    int v;
    if (!de) return 4'd0;
    if (mode == 2'd1) begin
      v = (int'(c) + int'(t)) / 4;
      if (v > 15) v = 15;
    end else begin
      v = (int'(c) + 4 * int'(t)) / 16;
      if (v > 3) v = 3;
    end
    return 4'(v);
  endfunction

  function automatic logic [23:0] pins(input logic [1:0] mode, input logic [3:0] r,
                                       input logic [3:0] g, input logic [3:0] b,
                                       input logic hs, input logic vs);
    if (mode == 2'd1) return {b, r, 2'b00, vs, hs, g, 8'hFF};
    if (mode == 2'd0) return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1], 16'h0000};
    return {hs, 3'b000, vs, 3'b000, 16'h0000};
  endfunction

  // Monitor: compare every expectation on the cycle its pins are due.
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("uo_out",  uo_out,  e.uo);
      chk("uio_out", uio_out, e.uio);
      chk("uio_oe",  uio_oe,  e.oe);
    end
  end

  // One pixel clock of stimulus; called at a falling edge.
  task automatic step(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                      input logic hs, input logic vs, input logic de);
    logic       vs_act, edge_v, x, y;
    logic [1:0] t, nm;
    exp_t       e;
    vs_act = ~vs;
    edge_v = vs_act & ~m_vs_prev;
    nm     = edge_v ? r_m2 : m_mode;
    x      = m_px ^ m_fp;
    y      = m_ln ^ m_fp;
    t      = bayer(x, y);
    e.due  = cyc + 2;
    {e.uo, e.uio, e.oe} = pins(nm, dith(r, de, nm, t), dith(g, de, nm, t),
                               dith(b, de, nm, t), hs, vs);
    sb.push_back(e);
    r_in = r; g_in = g; b_in = b; hs_in = hs; vs_in = vs; de_in = de; mode_req = req;
    if (edge_v)                 m_ln = 1'b0;
    else if (m_de_prev && !de)  m_ln = ~m_ln;
    m_px      = de ? ~m_px : 1'b0;
    m_fp      = m_fp ^ edge_v;
    m_mode    = nm;
    m_de_prev = de;
    m_vs_prev = vs_act;
    r_m2      = r_m1;
    r_m1      = req;
    @(negedge clk);
    chk("mode_active", {6'b0, mode_active}, {6'b0, nm});
  endtask

  task automatic line(input int n, input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    for (int i = 0; i < n; i++) step(r, g, b, 1'b1, 1'b1, 1'b1);
    step(r, g, b, 1'b1, 1'b1, 1'b0);
    step(r, g, b, 1'b0, 1'b1, 1'b0);
    step(r, g, b, 1'b0, 1'b1, 1'b0);
    step(r, g, b, 1'b1, 1'b1, 1'b0);
  endtask

  // Vertical sync; edge_req is put on mode_req in the same cycle as the assertion edge.
  task automatic vsync(input logic [1:0] edge_req);
    req = edge_req;
    step(6'h3F, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
    step(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    step(6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
    step(6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset uo_out",      uo_out,  8'h88);
    chk("reset uio_out",     uio_out, 8'h00);
    chk("reset uio_oe",      uio_oe,  8'h00);
    chk("reset mode_active", {6'b0, mode_active}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0: saturated white, then mid-level dithered colour
    line(4, 6'h3F, 6'h3F, 6'h3F);
    line(6, 6'h20, 6'h10, 6'h2A);

    // Request mode 1; adopted only at the vs edge
    req = 2'd1;
    line(4, 6'h20, 6'h10, 6'h2A);
    vsync(2'd1);
    line(6, 6'd2, 6'd5, 6'h3F);
    line(6, 6'd2, 6'h21, 6'h0F);
    vsync(2'd1);
    line(6, 6'd2, 6'd5, 6'h3F);
    line(6, 6'd2, 6'h21, 6'h0F);

    // Back to mode 0 at the next frame, then 0->1 with a mid-frame pulse
    req = 2'd0;
    line(4, 6'h17, 6'h28, 6'h33);
    vsync(2'd0);
    req = 2'd1;
    line(4, 6'h17, 6'h28, 6'h33);
    req = 2'd0;
    step(6'h3F, 6'h3F, 6'h3F, 1'b1, 1'b1, 1'b1);
    step(6'h3F, 6'h3F, 6'h3F, 1'b1, 1'b1, 1'b1);
    req = 2'd1;
    line(4, 6'h17, 6'h28, 6'h33);
    vsync(2'd1);

    // Request change coincident with the vs edge waits a frame
    line(4, 6'h09, 6'h1B, 6'h2D);
    vsync(2'd2);
    line(4, 6'h3F, 6'h3F, 6'h3F);
    vsync(2'd2);
    line(4, 6'h3F, 6'h3F, 6'h3F);
    req = 2'd3;
    line(4, 6'h3F, 6'h3F, 6'h3F);
    vsync(2'd3);
    line(4, 6'h3F, 6'h3F, 6'h3F);

    // Mode 1 blanking with nonzero colour and toggling hsync
    req = 2'd1;
    line(4, 6'h01, 6'h02, 6'h03);
    vsync(2'd1);
    for (int i = 0; i < 6; i++) step(6'h3F, 6'h3F, 6'h3F, i[0], 1'b1, 1'b0);

    // Asynchronous reset mid-line
    step(6'h3F, 6'h3F, 6'h3F, 1'b1, 1'b1, 1'b1);
    step(6'h3F, 6'h3F, 6'h3F, 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    r_in = '0; g_in = '0; b_in = '0; hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0;
    #1;
    sb.delete();
    chk("midreset uo_out",      uo_out,  8'h88);
    chk("midreset uio_out",     uio_out, 8'h00);
    chk("midreset uio_oe",      uio_oe,  8'h00);
    chk("midreset mode_active", {6'b0, mode_active}, 8'h00);
    m_px = 0; m_ln = 0; m_fp = 0; m_de_prev = 0; m_vs_prev = 0;
    m_mode = 2'd0; r_m1 = req; r_m2 = req;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // After release: mode 0 until the first vs edge re-evaluates the request
    line(4, 6'h3F, 6'h20, 6'h05);
    vsync(2'd1);
    line(4, 6'h3F, 6'h20, 6'h05);

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
